// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared types and load-type encodings for the LSU port arbiter
package lsu_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_e;
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [3:0]  bmask;
    logic [2:0]  ld_sel;
  } lsu_req_t;
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
endpackage

// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: two-master round-robin/fixed-priority arbiter for the LSU port with bounded lock
module lsu_port_arbiter
  import lsu_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int LOCK_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_lock,
  input  logic [15:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_wr_en,
  input  logic [3:0]  m0_bmask,
  input  logic [2:0]  m0_ld_sel,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_lock,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_wr_en,
  input  logic [3:0]  m1_bmask,
  input  logic [2:0]  m1_ld_sel,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [15:0] lsu_addr,
  output logic [31:0] lsu_w_data,
  output logic        lsu_wr_en,
  output logic [3:0]  lsu_bmask,
  output logic [2:0]  lsu_ld_sel,
  input  logic [31:0] lsu_r_data,
  output logic        grant_id
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  arb_state_e  r_state;
  logic        r_rr_ptr;
  logic [CW-1:0] r_lock_cnt;
  logic [1:0]  r_rvalid;
  logic [31:0] r_rdata0, r_rdata1;
  lsu_req_t    w_req0, w_req1, w_req;
  logic        w_grant, w_fire, w_lock, w_timeout;
  logic [CW-1:0] w_cnt_inc;
  assign w_req0 = {m0_addr, m0_wdata, m0_wr_en, m0_bmask, m0_ld_sel};
  assign w_req1 = {m1_addr, m1_wdata, m1_wr_en, m1_bmask, m1_ld_sel};
  // With no requester in IDLE the grant parks on rr_ptr
  assign w_grant = (r_state == ARB_OWN0) ? 1'b0 :
                   (r_state == ARB_OWN1) ? 1'b1 :
                   (m0_valid && m1_valid) ? (FIXED_PRIO ? 1'b0 : r_rr_ptr) :
                   m0_valid ? 1'b0 : m1_valid ? 1'b1 : r_rr_ptr;
  assign w_fire    = rst_n & (w_grant ? m1_valid : m0_valid);
  assign w_lock    = w_grant ? m1_lock : m0_lock;
  assign w_req     = w_grant ? w_req1 : w_req0;
  assign w_cnt_inc = (r_lock_cnt == CW'(LOCK_MAX)) ? r_lock_cnt : r_lock_cnt + CW'(1);
  assign w_timeout = (w_cnt_inc == CW'(LOCK_MAX));
  assign m0_ready   = w_fire & ~w_grant;
  assign m1_ready   = w_fire & w_grant;
  assign lsu_addr   = w_req.addr;
  assign lsu_w_data = w_req.wdata;
  assign lsu_wr_en  = w_fire & w_req.wr_en;
  assign lsu_bmask  = w_req.bmask;
  assign lsu_ld_sel = w_req.ld_sel;
  assign grant_id   = w_grant;
  assign m0_rvalid  = r_rvalid[0];
  assign m1_rvalid  = r_rvalid[1];
  assign m0_rdata   = r_rdata0;
  assign m1_rdata   = r_rdata1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= 1'b0;
      r_lock_cnt <= '0;
      r_rvalid   <= 2'b00;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_rvalid <= {m1_ready, m0_ready};
      if (m0_ready) r_rdata0 <= w_req.wr_en ? 32'h0 : lsu_r_data;
      if (m1_ready) r_rdata1 <= w_req.wr_en ? 32'h0 : lsu_r_data;
      if (r_state == ARB_IDLE) begin
        r_lock_cnt <= (w_fire && w_lock) ? CW'(1) : '0;
        if (w_fire) begin
          r_rr_ptr <= ~w_grant;
          if (w_lock) r_state <= w_grant ? ARB_OWN1 : ARB_OWN0;
        end
      end else begin
        r_lock_cnt <= w_cnt_inc;
        // Timeout wins over the lock bit; the timeout-cycle transfer still fires
        if (w_timeout || (w_fire && !w_lock)) begin
          r_state  <= ARB_IDLE;
          r_rr_ptr <= ~w_grant;
        end
      end
    end
  end
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb_lsu_port_arbiter: directed checks on three arbiter configurations sharing one stimulus
module tb_lsu_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m0_lock, m0_wr_en, m1_valid, m1_lock, m1_wr_en;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_bmask, m1_bmask;
  logic [2:0]  m0_ld_sel, m1_ld_sel;
  logic [2:0]  rdy0, rdy1, rv0, rv1, wen, gid;
  logic [31:0] rd0 [3];
  logic [31:0] rd1 [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic [15:0] la [3];
  logic [3:0]  bm [3];
  logic [2:0]  ls [3];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  // Instance 0: round-robin, LOCK_MAX=16; 1: fixed priority; 2: round-robin, LOCK_MAX=4
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rdat[g] = (la[g] == 16'h0010) ? 32'hDEADBEEF : {16'hA5A5, la[g]};
    lsu_port_arbiter #(.FIXED_PRIO(g == 1), .LOCK_MAX(g == 2 ? 4 : 16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_valid(m0_valid), .m0_ready(rdy0[g]), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wr_en(m0_wr_en), .m0_bmask(m0_bmask), .m0_ld_sel(m0_ld_sel),
      .m0_rvalid(rv0[g]), .m0_rdata(rd0[g]),
      .m1_valid(m1_valid), .m1_ready(rdy1[g]), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wr_en(m1_wr_en), .m1_bmask(m1_bmask), .m1_ld_sel(m1_ld_sel),
      .m1_rvalid(rv1[g]), .m1_rdata(rd1[g]),
      .lsu_addr(la[g]), .lsu_w_data(wdat[g]), .lsu_wr_en(wen[g]), .lsu_bmask(bm[g]),
      .lsu_ld_sel(ls[g]), .lsu_r_data(rdat[g]), .grant_id(gid[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set_m0(input logic v, input logic lk, input logic wr, input logic [15:0] a, input logic [31:0] d);
    m0_valid = v; m0_lock = lk; m0_wr_en = wr; m0_addr = a; m0_wdata = d; m0_bmask = 4'hF; m0_ld_sel = 3'b010;
  endtask
  task automatic set_m1(input logic v, input logic lk, input logic wr, input logic [15:0] a, input logic [31:0] d);
    m1_valid = v; m1_lock = lk; m1_wr_en = wr; m1_addr = a; m1_wdata = d; m1_bmask = 4'hF; m1_ld_sel = 3'b010;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    set_m0(0, 0, 0, 16'h0, 32'h0);
    set_m1(0, 0, 0, 16'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    set_m0(1, 0, 1, 16'h0010, 32'h1);
    set_m1(1, 0, 1, 16'h0020, 32'h2);
    @(negedge clk);
    check("rst_m0_ready", 32'(rdy0), 32'h0);
    check("rst_m1_ready", 32'(rdy1), 32'h0);
    check("rst_wr_en", 32'(wen), 32'h0);
    check("rst_rvalid", 32'({rv1, rv0}), 32'h0);
    check("rst_rdata", rd0[0] | rd1[0], 32'h0);
    check("rst_grant", 32'(gid), 32'h0);
    do_reset();
    set_m0(1, 0, 0, 16'h0010, 32'h0);
    @(negedge clk);
    check("single_ready0", 32'(rdy0[0]), 32'h1);
    check("single_ready1", 32'(rdy1[0]), 32'h0);
    check("single_wr_en", 32'(wen[0]), 32'h0);
    check("single_addr", 32'(la[0]), 32'h0010);
    check("single_ld_sel", 32'(ls[0]), 32'h2);
    cyc();
    set_m0(0, 0, 0, 16'h0, 32'h0);
    check("single_rvalid0", 32'(rv0[0]), 32'h1);
    check("single_rdata0", rd0[0], 32'hDEADBEEF);
    check("single_rvalid1", 32'(rv1[0]), 32'h0);
    check("single_rdata1", rd1[0], 32'h0);
    cyc();
    check("single_rvalid_clear", 32'(rv0[0]), 32'h0);
    do_reset();
    set_m0(1, 0, 0, 16'h0020, 32'h0);
    set_m1(1, 0, 0, 16'h0030, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rr_grant_%0d", i), 32'(gid[0]), 32'(i % 2));
      check($sformatf("fp_grant_%0d", i), 32'(gid[1]), 32'h0);
      check($sformatf("fp_ready1_%0d", i), 32'(rdy1[1]), 32'h0);
      cyc();
      check($sformatf("rr_rvalid0_%0d", i), 32'(rv0[0]), 32'(i % 2 == 0));
      check($sformatf("rr_rvalid1_%0d", i), 32'(rv1[0]), 32'(i % 2 == 1));
    end
    check("rr_rdata1", rd1[0], 32'hA5A50030);
    do_reset();
    set_m0(1, 0, 0, 16'h0020, 32'h0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      set_m1(1, i < 3, 1, 16'h0100, 32'(i + 16'h50));
      @(negedge clk);
      check($sformatf("burst_ready0_%0d", i), 32'(rdy0[0]), 32'h0);
      check($sformatf("burst_ready1_%0d", i), 32'(rdy1[0]), 32'h1);
      check($sformatf("burst_wr_en_%0d", i), 32'(wen[0]), 32'h1);
      check($sformatf("burst_wdata_%0d", i), wdat[0], 32'(i + 16'h50));
      cyc();
    end
    @(negedge clk);
    check("burst_after_grant", 32'(gid[0]), 32'h0);
    check("burst_after_ready0", 32'(rdy0[0]), 32'h1);
    do_reset();
    set_m0(1, 1, 0, 16'h0020, 32'h0);
    set_m1(1, 0, 0, 16'h0030, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("tmo_grant_%0d", i), 32'(gid[2]), 32'h0);
      check($sformatf("tmo_ready0_%0d", i), 32'(rdy0[2]), 32'h1);
      cyc();
    end
    @(negedge clk);
    check("tmo_cycle5_grant", 32'(gid[2]), 32'h1);
    check("tmo_cycle5_ready1", 32'(rdy1[2]), 32'h1);
    check("nolimit_cycle5_ready1", 32'(rdy1[0]), 32'h0);
    do_reset();
    set_m1(1, 0, 1, 16'h4000, 32'h0000_00FF);
    @(negedge clk);
    check("store_wr_en", 32'(wen[0]), 32'h1);
    check("store_addr", 32'(la[0]), 32'h4000);
    check("store_bmask", 32'(bm[0]), 32'hF);
    check("store_wdata", wdat[0], 32'h0000_00FF);
    cyc();
    set_m1(0, 0, 0, 16'h0, 32'h0);
    check("store_rvalid1", 32'(rv1[0]), 32'h1);
    check("store_rdata1", rd1[0], 32'h0);
    @(negedge clk);
    check("store_wr_en_once", 32'(wen[0]), 32'h0);
    do_reset();
    set_m0(1, 1, 0, 16'h0010, 32'h0);
    cyc();
    check("midlock_rvalid_pre", 32'(rv0[0]), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midlock_rvalid_drop", 32'(rv0[0]), 32'h0);
    check("midlock_ready_drop", 32'(rdy0[0]), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_m0(1, 0, 0, 16'h0020, 32'h0);
    set_m1(1, 0, 0, 16'h0030, 32'h0);
    @(negedge clk);
    check("midlock_after_grant", 32'(gid[0]), 32'h0);
    check("midlock_after_ready0", 32'(rdy0[0]), 32'h1);
    check("midlock_after_ready1", 32'(rdy1[0]), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
